// File: rtl/vga_timing_pkg.sv
// Shared timing-set records and standard raster modes
// for the VGA timing generator.
package vga_timing_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
    logic        pol;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } timing_t;

  localparam timing_t VGA_640x480_60 = '{
    h: '{active: 16'd640, fp: 16'd16, sync: 16'd96,
         bp: 16'd48, pol: 1'b0},
    v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,
         bp: 16'd33, pol: 1'b0}
  };

  localparam timing_t SVGA_800x600_60 = '{
    h: '{active: 16'd800, fp: 16'd40, sync: 16'd128,
         bp: 16'd88, pol: 1'b1},
    v: '{active: 16'd600, fp: 16'd1, sync: 16'd4,
         bp: 16'd23, pol: 1'b1}
  };

  function automatic int unsigned total(axis_timing_t t);
    return 32'(t.active) + 32'(t.fp)
         + 32'(t.sync) + 32'(t.bp);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator and
// pixel consumers.
interface vga_timing_gen_if
  import vga_timing_pkg::*;
#(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
);
  logic          pix_en;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  pix_en,
    output hsync, vsync, de, x, y,
    output line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, de, x, y,
    input  line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus combinational
// decode of the current count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync,
  output logic         first
);
  localparam axis_timing_t T = '{
    active: 16'(ACTIVE), fp: 16'(FP),
    sync: 16'(SYNC), bp: 16'(BP), pol: POL
  };
  localparam int unsigned TOTAL = total(T);

  // Inclusive bounds so a full 2^W range never truncates to 0
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] A_LAST  = W'(ACTIVE - 1);
  localparam logic [W-1:0] S_FIRST = W'(ACTIVE + FP);
  localparam logic [W-1:0] S_LAST  = W'(ACTIVE + FP + SYNC - 1);

  logic [W-1:0] r_cnt;
  logic         w_in_sync;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (step)
      r_cnt <= wrap ? '0 : r_cnt + 1'b1;
  end

  assign w_in_sync = (r_cnt >= S_FIRST) && (r_cnt <= S_LAST);

  assign cnt    = r_cnt;
  assign wrap   = (r_cnt == LAST);
  assign active = (r_cnt <= A_LAST);
  assign sync   = w_in_sync ? POL : !POL;
  assign first  = (r_cnt == '0);
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator driven by a pixel-rate enable;
// every output is a registered decode of (h,v).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 32'(VGA_640x480_60.h.active),
  parameter int unsigned H_FP     = 32'(VGA_640x480_60.h.fp),
  parameter int unsigned H_SYNC   = 32'(VGA_640x480_60.h.sync),
  parameter int unsigned H_BP     = 32'(VGA_640x480_60.h.bp),
  parameter int unsigned V_ACTIVE = 32'(VGA_640x480_60.v.active),
  parameter int unsigned V_FP     = 32'(VGA_640x480_60.v.fp),
  parameter int unsigned V_SYNC   = 32'(VGA_640x480_60.v.sync),
  parameter int unsigned V_BP     = 32'(VGA_640x480_60.v.bp),
  parameter bit          HS_POL   = VGA_640x480_60.h.pol,
  parameter bit          VS_POL   = VGA_640x480_60.v.pol,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  bus
);
  localparam int unsigned V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [XW-1:0] w_h_cnt;
  logic [YW-1:0] w_v_cnt;
  logic w_h_wrap, w_h_act, w_h_sync, w_h_first;
  logic w_v_wrap, w_v_act, w_v_sync, w_v_first;
  logic w_v_step;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic r_de, r_hs, r_vs, r_ls, r_fs;

  assign w_v_step = bus.pix_en && w_h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC),
    .BP(H_BP), .POL(HS_POL), .W(XW)
  ) u_h (
    .clk(clk), .rst(rst), .step(bus.pix_en),
    .cnt(w_h_cnt), .wrap(w_h_wrap),
    .active(w_h_act), .sync(w_h_sync),
    .first(w_h_first)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC),
    .BP(V_BP), .POL(VS_POL), .W(YW)
  ) u_v (
    .clk(clk), .rst(rst), .step(w_v_step),
    .cnt(w_v_cnt), .wrap(w_v_wrap),
    .active(w_v_act), .sync(w_v_sync),
    .first(w_v_first)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x  <= '0;
      r_y  <= '0;
      r_de <= 1'b0;
      r_hs <= !HS_POL;
      r_vs <= !VS_POL;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end else begin
      r_ls <= 1'b0;
      r_fs <= 1'b0;
      if (bus.pix_en) begin
        r_x  <= w_h_cnt;
        r_y  <= w_v_cnt;
        r_de <= w_h_act && w_v_act;
        r_hs <= w_h_sync;
        r_vs <= w_v_sync;
        r_ls <= w_h_first;
        r_fs <= w_h_first && w_v_first;
      end
    end
  end

  // The last pixel of a frame must present the last line
  a_frame_wrap: assert property (
    @(posedge clk) disable iff (rst)
    (bus.pix_en && w_h_wrap && w_v_wrap)
      |=> (r_y == YW'(V_TOTAL - 1))
  );

  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.de          = r_de;
  assign bus.hsync       = r_hs;
  assign bus.vsync       = r_vs;
  assign bus.line_start  = r_ls;
  assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: small raster (both polarities) against a
// reference model, plus default 640x480 line checks.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic de, hs, vs, ls, fs;
  } exp_t;

  typedef struct {
    bit   r;
    bit   e;
    exp_t ex;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s = 1'b1;
  logic rst_p = 1'b1;
  logic rst_d = 1'b1;

  vga_timing_gen_if #(.XW(10), .YW(10)) s_if ();
  vga_timing_gen_if #(.XW(10), .YW(10)) p_if ();
  vga_timing_gen_if #(.XW(10), .YW(10)) d_if ();

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .XW(10), .YW(10)
  ) u_s (.clk(clk), .rst(rst_s), .bus(s_if.master));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .XW(10), .YW(10)
  ) u_p (.clk(clk), .rst(rst_p), .bus(p_if.master));

  vga_timing_gen #(.XW(10), .YW(10)) u_d (
    .clk(clk), .rst(rst_d), .bus(d_if.master)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  exp_t last;
  int   max_x = 0;
  int   max_y = 0;

  int   m_h[2];
  int   m_v[2];
  exp_t m_out[2];

  function automatic exp_t decode(int h, int v, bit pol);
    exp_t e;
    e.x  = 10'(h);
    e.y  = 10'(v);
    e.de = (h < 4) && (v < 3);
    e.hs = (h >= 5 && h <= 6) ? pol : ~pol;
    e.vs = (v == 4) ? pol : ~pol;
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic exp_t mk(int x, int y, bit de,
    bit hs, bit vs, bit ls, bit fs);
    exp_t e;
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.de = de;
    e.hs = hs;
    e.vs = vs;
    e.ls = ls;
    e.fs = fs;
    return e;
  endfunction

  function automatic exp_t sample(int w);
    exp_t g;
    case (w)
      0: g = {s_if.x, s_if.y, s_if.de, s_if.hsync,
              s_if.vsync, s_if.line_start,
              s_if.frame_start};
      1: g = {p_if.x, p_if.y, p_if.de, p_if.hsync,
              p_if.vsync, p_if.line_start,
              p_if.frame_start};
      default: g = {d_if.x, d_if.y, d_if.de,
              d_if.hsync, d_if.vsync,
              d_if.line_start, d_if.frame_start};
    endcase
    return g;
  endfunction

  task automatic drive(int w, bit r, bit e);
    case (w)
      0: begin rst_s = r; s_if.pix_en = e; end
      1: begin rst_p = r; p_if.pix_en = e; end
      default: begin rst_d = r; d_if.pix_en = e; end
    endcase
  endtask

  task automatic chk(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, got, exp);
    end
  endtask

  task automatic apply(int w, bit r, bit e,
    exp_t ex, string tag);
    exp_t g;
    exp_t x;
    drive(w, r, e);
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    g = sample(w);
    last = g;
    if (int'(g.x) > max_x) max_x = int'(g.x);
    if (int'(g.y) > max_y) max_y = int'(g.y);
    x = sb_q.pop_front();
    n_cmp++;
    if (g !== x) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b expected x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
        tag, g.x, g.y, g.de, g.hs, g.vs, g.ls, g.fs,
        x.x, x.y, x.de, x.hs, x.vs, x.ls, x.fs);
    end
  endtask

  task automatic step(int w, bit r, bit e, string tag);
    exp_t ex;
    bit pol;
    pol = (w == 1);
    if (r) begin
      ex = mk(0, 0, 0, ~pol, ~pol, 0, 0);
      m_h[w] = 0;
      m_v[w] = 0;
    end else if (e) begin
      ex = decode(m_h[w], m_v[w], pol);
      if (m_h[w] == 7) begin
        m_h[w] = 0;
        m_v[w] = (m_v[w] == 5) ? 0 : m_v[w] + 1;
      end else begin
        m_h[w] = m_h[w] + 1;
      end
    end else begin
      ex = m_out[w];
      ex.ls = 1'b0;
      ex.fs = 1'b0;
    end
    m_out[w] = ex;
    apply(w, r, e, ex, tag);
  endtask

  initial begin
    vec_t tbl[14];
    int fs_cyc[$];
    int ls_n;
    int ls_cyc[$];
    int ls_y[$];
    int hs_cnt, hs_w, hs_fall_x;
    int de_cnt, de_w, vs_low, dmax;
    bit prev_hs, prev_de;
    exp_t g;

    s_if.pix_en = 1'b0;
    p_if.pix_en = 1'b0;
    d_if.pix_en = 1'b0;

    tbl[0]  = '{1, 0, mk(0, 0, 0, 1, 1, 0, 0)};
    tbl[1]  = '{0, 1, mk(0, 0, 1, 1, 1, 1, 1)};
    tbl[2]  = '{0, 0, mk(0, 0, 1, 1, 1, 0, 0)};
    tbl[3]  = '{0, 1, mk(1, 0, 1, 1, 1, 0, 0)};
    tbl[4]  = '{0, 1, mk(2, 0, 1, 1, 1, 0, 0)};
    tbl[5]  = '{0, 1, mk(3, 0, 1, 1, 1, 0, 0)};
    tbl[6]  = '{0, 1, mk(4, 0, 0, 1, 1, 0, 0)};
    tbl[7]  = '{0, 1, mk(5, 0, 0, 0, 1, 0, 0)};
    tbl[8]  = '{0, 0, mk(5, 0, 0, 0, 1, 0, 0)};
    tbl[9]  = '{0, 1, mk(6, 0, 0, 0, 1, 0, 0)};
    tbl[10] = '{0, 1, mk(7, 0, 0, 1, 1, 0, 0)};
    tbl[11] = '{0, 1, mk(0, 1, 1, 1, 1, 1, 0)};
    tbl[12] = '{1, 1, mk(0, 0, 0, 1, 1, 0, 0)};
    tbl[13] = '{0, 1, mk(0, 0, 1, 1, 1, 1, 1)};

    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++)
      apply(0, tbl[i].r, tbl[i].e, tbl[i].ex,
            $sformatf("vec%0d", i));

    // Full-rate small raster over two frames
    step(0, 1, 0, "s_rst");
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 1, "s_run");
      if (last.fs) fs_cyc.push_back(i);
    end
    chk("s_fs_count", fs_cyc.size(), 3);
    if (fs_cyc.size() >= 2)
      chk("s_fs_period", fs_cyc[1] - fs_cyc[0], 48);

    // 1-in-4 enable
    fs_cyc.delete();
    ls_n = 0;
    step(0, 1, 0, "t_rst");
    for (int i = 0; i < 400; i++) begin
      step(0, 0, (i % 4) == 0, "t_run");
      if (last.fs) fs_cyc.push_back(i);
      if (last.ls) ls_n++;
    end
    chk("t_fs_count", fs_cyc.size(), 3);
    if (fs_cyc.size() >= 2)
      chk("t_fs_period", fs_cyc[1] - fs_cyc[0], 192);
    chk("t_ls_clks", ls_n, 13);

    // Reset in the middle of the vsync line
    step(0, 1, 0, "r_rst");
    for (int i = 0; i < 48; i++) begin
      if (m_h[0] == 6 && m_v[0] == 4) break;
      step(0, 0, 1, "r_run");
    end
    chk("r_pre_vs", int'(last.vs), 0);
    step(0, 1, 1, "r_mid");
    chk("r_mid_x", int'(last.x), 0);
    chk("r_mid_y", int'(last.y), 0);
    chk("r_mid_de", int'(last.de), 0);
    step(0, 0, 1, "r_first");
    chk("r_first_fs", int'(last.fs), 1);

    // Last pixel of the frame then wrap to (0,0)
    step(0, 1, 0, "w_rst");
    for (int i = 0; i < 47; i++)
      step(0, 0, 1, "w_run");
    step(0, 0, 1, "w_last");
    chk("w_last_x", int'(last.x), 7);
    chk("w_last_y", int'(last.y), 5);
    step(0, 0, 1, "w_wrap");
    chk("w_wrap_x", int'(last.x), 0);
    chk("w_wrap_y", int'(last.y), 0);
    chk("w_wrap_fs", int'(last.fs), 1);
    chk("s_max_x", max_x, 7);
    chk("s_max_y", max_y, 5);

    // Active-high sync polarity
    step(1, 1, 0, "p_rst");
    chk("p_rst_hs", int'(last.hs), 0);
    chk("p_rst_vs", int'(last.vs), 0);
    for (int i = 0; i < 60; i++)
      step(1, 0, 1, "p_run");

    // Default 640x480 timing, first three lines
    drive(2, 1, 0);
    @(posedge clk);
    #1;
    g = sample(2);
    chk("d_rst_x", int'(g.x), 0);
    chk("d_rst_de", int'(g.de), 0);
    chk("d_rst_hs", int'(g.hs), 1);
    chk("d_rst_vs", int'(g.vs), 1);
    chk("d_rst_ls", int'(g.ls), 0);
    drive(2, 0, 1);
    hs_cnt = 0; hs_w = -1; hs_fall_x = -1;
    de_cnt = 0; de_w = -1; vs_low = 0; dmax = 0;
    prev_hs = 1'b1;
    prev_de = 1'b0;
    for (int c = 1; c <= 2500; c++) begin
      @(posedge clk);
      #1;
      g = sample(2);
      if (g.ls) begin
        ls_cyc.push_back(c);
        ls_y.push_back(int'(g.y));
      end
      if (!g.hs) begin
        hs_cnt++;
        if (prev_hs && hs_fall_x < 0)
          hs_fall_x = int'(g.x);
      end else if (!prev_hs && hs_w < 0) begin
        hs_w = hs_cnt;
      end
      if (g.de) de_cnt++;
      else if (prev_de && de_w < 0) de_w = de_cnt;
      if (!g.vs) vs_low++;
      if (int'(g.x) > dmax) dmax = int'(g.x);
      prev_hs = g.hs;
      prev_de = g.de;
    end
    drive(2, 0, 0);
    chk("d_ls_count", ls_cyc.size(), 4);
    if (ls_cyc.size() >= 2) begin
      chk("d_ls_first", ls_cyc[0], 1);
      chk("d_line_period", ls_cyc[1] - ls_cyc[0], 800);
      chk("d_line1_y", ls_y[1], 1);
    end
    chk("d_hs_fall_x", hs_fall_x, 656);
    chk("d_hs_width", hs_w, 96);
    chk("d_de_run", de_w, 640);
    chk("d_vs_low", vs_low, 0);
    chk("d_max_x", dmax, 799);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/raster timing generator that produces horizontal and vertical sync, display-enable and pixel coordinates. It runs from the system clock, and a pixel-rate clock enable sets the pixel rate, so no derived clock is generated. Porch, sync and active widths and sync polarities are parameters. It sits between the system clock domain and any pixel-pattern or framebuffer reader, which consume `de`, `x` and `y` plus line and frame strobes.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `HS_POL`, 0: hsync asserted level (0 = active-low)
- `VS_POL`, 0: vsync asserted level (0 = active-low)
- `XW`, 10: width of `x`; must satisfy 2^XW ≥ H_TOTAL
- `YW`, 10: width of `y`; must satisfy 2^YW ≥ V_TOTAL
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined likewise.

Ports:
- `clk`, in, 1: system clock. One clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous active-high reset.
- `pix_en`, in, 1: pixel-rate enable; one pixel advances per `clk` cycle with `pix_en`=1.
- `hsync`, out, 1: horizontal sync, at polarity `HS_POL`.
- `vsync`, out, 1: vertical sync, at polarity `VS_POL`.
- `de`, out, 1: display enable; high only inside the active area.
- `x`, out, XW: current horizontal position, 0..H_TOTAL-1.
- `y`, out, YW: current line, 0..V_TOTAL-1.
- `line_start`, out, 1: one-`clk` strobe at pixel x=0 of every line.
- `frame_start`, out, 1: one-`clk` strobe at pixel (0,0).

## Operation
- Internal counters `h` (0..H_TOTAL-1) and `v` (0..V_TOTAL-1) advance only on `clk` edges where `pix_en`=1.
- When `h`=H_TOTAL-1, `h` wraps to 0 and `v` increments.
- When `v` is also V_TOTAL-1, `v` wraps to 0.
- There are no terminal-count overshoots: the count H_TOTAL is never reached.
- On each `pix_en` edge, all outputs register a decode of the pre-increment (`h`,`v`):
  - `x`=`h` and `y`=`v`; both also count through the blanking interval.
  - `de` = (`h`<H_ACTIVE) && (`v`<V_ACTIVE).
  - `hsync` is asserted for `h` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. This is exactly H_SYNC pixels.
  - `vsync` is asserted for `v` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. This is exactly V_SYNC whole lines, with edges aligned to `h`=0.
  - `line_start` = (`h`==0); `frame_start` = (`h`==0 && `v`==0).
- When `pix_en`=0, `x`, `y`, `de`, `hsync` and `vsync` hold their values. `line_start` and `frame_start` clear to 0.
- Reset values:
  - `h`=`v`=0, `x`=`y`=0, `de`=0.
  - `hsync`=!HS_POL and `vsync`=!VS_POL, i.e. deasserted.
  - `line_start`=`frame_start`=0.
- Reset mid-frame: the next cycle shows the reset values; the frame restarts at (0,0). `rst` has priority over `pix_en`.
- `pix_en` stuck at 1 gives a 1 pixel/clk raster. `pix_en` stuck at 0 freezes all outputs except the strobes, which stay 0.

## Timing
- Latency: outputs for pixel (h,v) appear one `clk` after the `pix_en` edge that consumed (h,v). All outputs are registered, so none has a combinational path from any input.
- The first `pix_en` edge after reset release yields `frame_start`=`line_start`=`de`=1 and `x`=`y`=0.
- Line period is H_TOTAL `pix_en` edges; frame period is H_TOTAL·V_TOTAL `pix_en` edges.
- The `de` high run per active line is exactly H_ACTIVE `pix_en` edges; active lines per frame are exactly V_ACTIVE.
- Strobes are high for exactly one `clk`, independent of the `pix_en` duty cycle.

## Structure
- Package `vga_timing_pkg` holds:
  - A timing-set record (active/fp/sync/bp/pol per axis).
  - Constants `VGA_640x480_60` and `SVGA_800x600_60`.
  - A `total()` helper function.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal and vertical):
  - Parameters: ACTIVE, FP, SYNC, BP, POL, W.
  - Inputs: `clk`, `rst`, `step`.
  - Outputs: `cnt`, `wrap`, `active`, `sync`, `first`.
  - The horizontal instance steps on `pix_en`; the vertical instance steps on `pix_en && h_wrap`.
  - The top level registers the outputs.

## Test plan
- **Small raster:** reset, then `pix_en`=1 with H=4/1/2/1 and V=3/1/1/1 → `x` sequence 0..7 repeating. `hsync` low exactly at `x`=5,6. `de` high at `x`=0..3 for `y`=0..2. `vsync` low for all of `y`=4. `frame_start` every 48 clks.
- **Default 640x480 full frame:** run a full frame → 800 clks/line, 420000 clks/frame. `de` count 307200. `hsync` pulse 96 clks. `vsync` pulse 1600 clks.
- **Throttled enable:** `pix_en` 1-in-4 → all periods ×4. Outputs hold between enables. `line_start` width is 1 clk.
- **Polarity:** `HS_POL`=`VS_POL`=1 → sync pulses high. Reset value of `hsync`/`vsync` is 0.
- **Reset at `x`=300, `y`=200:** next clk shows `x`=`y`=0, `de`=0. The first enable afterwards gives `frame_start`=1.
- **Wrap corner:** at `h`=H_TOTAL-1, `v`=V_TOTAL-1 → next enable gives `x`=`y`=0 with `frame_start`=1. No value ≥ H_TOTAL/V_TOTAL is ever observed.
